// File: rtl/alu_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : alu_ctrl_if
// Description : Receive, ALU-load and transmit signal bundle for alu_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_ctrl_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_DATA-1:0] o_alu_data;
    logic               o_alu_en_a;
    logic               o_alu_en_b;
    logic               o_alu_en_op;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_alu_carry;
    logic               i_alu_zero;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;
    logic               o_busy;
    logic               o_overrun;

    // Sequencer side
    modport master (
        input  i_rx_data, i_rx_valid,
        output o_alu_data, o_alu_en_a, o_alu_en_b, o_alu_en_op,
        input  i_alu_result, i_alu_carry, i_alu_zero,
        output o_tx_data, o_tx_valid,
        input  i_tx_ready,
        output o_busy, o_overrun
    );

    // Receiver / ALU / transmitter side
    modport slave (
        output i_rx_data, i_rx_valid,
        input  o_alu_data, o_alu_en_a, o_alu_en_b, o_alu_en_op,
        output i_alu_result, i_alu_carry, i_alu_zero,
        input  o_tx_data, o_tx_valid,
        output i_tx_ready,
        input  o_busy, o_overrun
    );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : alu_ctrl
// Description : Byte-stream sequencer feeding operands/opcode to an ALU and
//               returning the result (plus flags when ALU_CTRL_FLAGS_EN is set).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl #(
    parameter int                 NB_DATA  = 8,
    parameter int                 NB_OP    = 6,
    parameter int                 ALU_LAT  = 2,
    parameter logic [NB_DATA-1:0] ERR_CODE = 8'hEE
) (
    input  wire logic   i_clk,
    input  wire logic   i_reset,
    alu_ctrl_if.master  bus
);

    localparam int NB_STATE = 3;
    localparam int NB_CNT   = 4;

    localparam logic [NB_STATE-1:0] c_WAIT_A   = 3'd0;
    localparam logic [NB_STATE-1:0] c_WAIT_B   = 3'd1;
    localparam logic [NB_STATE-1:0] c_WAIT_OP  = 3'd2;
    localparam logic [NB_STATE-1:0] c_EXEC     = 3'd3;
    localparam logic [NB_STATE-1:0] c_SEND_RES = 3'd4;
`ifdef ALU_CTRL_FLAGS_EN
    localparam logic [NB_STATE-1:0] c_SEND_FLG = 3'd5;
`endif

    localparam logic [NB_OP-1:0] c_OP_ADD = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] c_OP_SUB = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] c_OP_AND = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] c_OP_OR  = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] c_OP_NOR = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] c_OP_XOR = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] c_OP_SRL = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] c_OP_SRA = NB_OP'(6'b000011);

    logic [NB_STATE-1:0] r_state;
    logic [NB_STATE-1:0] w_next_state;
    logic [NB_DATA-1:0]  r_alu_data;
    logic                r_en_a;
    logic                r_en_b;
    logic                r_en_op;
    logic [NB_CNT-1:0]   r_cnt;
    logic [NB_DATA-1:0]  r_tx_data;
    logic                r_overrun;
    logic [NB_OP-1:0]    w_opcode;
    logic                w_op_valid;
    logic                w_tx_fire;
`ifdef ALU_CTRL_FLAGS_EN
    logic [1:0]          r_flags;
    logic                r_op_ok;
`else
    logic                w_unused_flags;
    assign w_unused_flags = bus.i_alu_carry ^ bus.i_alu_zero;
`endif

    assign w_opcode  = bus.i_rx_data[NB_DATA-1 -: NB_OP];
    assign w_tx_fire = bus.o_tx_valid & bus.i_tx_ready;

    always_comb begin
        w_op_valid = 1'b0;
        case (w_opcode)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_NOR, c_OP_XOR, c_OP_SRL, c_OP_SRA: w_op_valid = 1'b1;
            default:                                w_op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_WAIT_A:   if (bus.i_rx_valid) w_next_state = c_WAIT_B;
            c_WAIT_B:   if (bus.i_rx_valid) w_next_state = c_WAIT_OP;
            c_WAIT_OP:  if (bus.i_rx_valid) w_next_state = w_op_valid ? c_EXEC : c_SEND_RES;
            c_EXEC:     if (r_cnt == '0)    w_next_state = c_SEND_RES;
            c_SEND_RES: begin
                if (w_tx_fire) begin
`ifdef ALU_CTRL_FLAGS_EN
                    w_next_state = r_op_ok ? c_SEND_FLG : c_WAIT_A;
`else
                    w_next_state = c_WAIT_A;
`endif
                end
            end
`ifdef ALU_CTRL_FLAGS_EN
            c_SEND_FLG: if (w_tx_fire) w_next_state = c_WAIT_A;
`endif
            default:    w_next_state = c_WAIT_A;
        endcase
    end

    always_comb begin
        bus.o_busy     = (r_state != c_WAIT_A);
        bus.o_tx_valid = (r_state == c_SEND_RES);
        bus.o_tx_data  = r_tx_data;
`ifdef ALU_CTRL_FLAGS_EN
        if (r_state == c_SEND_FLG) begin
            bus.o_tx_valid = 1'b1;
            bus.o_tx_data  = {{(NB_DATA-2){1'b0}}, r_flags};
        end
`endif
    end

    // Strobes are registered so each enable lines up with the byte it loads.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_alu_data <= '0;
            r_en_a     <= 1'b0;
            r_en_b     <= 1'b0;
            r_en_op    <= 1'b0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_overrun  <= 1'b0;
`ifdef ALU_CTRL_FLAGS_EN
            r_flags    <= '0;
            r_op_ok    <= 1'b0;
`endif
        end else begin
            r_en_a    <= 1'b0;
            r_en_b    <= 1'b0;
            r_en_op   <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                c_WAIT_A: begin
                    if (bus.i_rx_valid) begin
                        r_alu_data <= bus.i_rx_data;
                        r_en_a     <= 1'b1;
                    end
                end
                c_WAIT_B: begin
                    if (bus.i_rx_valid) begin
                        r_alu_data <= bus.i_rx_data;
                        r_en_b     <= 1'b1;
                    end
                end
                c_WAIT_OP: begin
                    if (bus.i_rx_valid) begin
                        if (w_op_valid) begin
                            r_alu_data <= bus.i_rx_data;
                            r_en_op    <= 1'b1;
                            r_cnt      <= NB_CNT'(ALU_LAT);
                        end else begin
                            r_tx_data  <= ERR_CODE;
                        end
`ifdef ALU_CTRL_FLAGS_EN
                        r_op_ok <= w_op_valid;
`endif
                    end
                end
                c_EXEC: begin
                    r_overrun <= bus.i_rx_valid;
                    if (r_cnt == '0) begin
                        r_tx_data <= bus.i_alu_result;
`ifdef ALU_CTRL_FLAGS_EN
                        r_flags   <= {bus.i_alu_carry, bus.i_alu_zero};
`endif
                    end else begin
                        r_cnt <= r_cnt - NB_CNT'(1);
                    end
                end
                default: r_overrun <= bus.i_rx_valid;
            endcase
        end
    end

    assign bus.o_alu_data  = r_alu_data;
    assign bus.o_alu_en_a  = r_en_a;
    assign bus.o_alu_en_b  = r_en_b;
    assign bus.o_alu_en_op = r_en_op;
    assign bus.o_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_ctrl
// Description : Scoreboard bench for alu_ctrl with a behavioural ALU model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl;

    localparam int         ALU_LAT = 2;
    localparam logic [7:0] ERR     = 8'hEE;
`ifdef ALU_CTRL_FLAGS_EN
    localparam int         N_RSP   = 2;
`else
    localparam int         N_RSP   = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_if #(.NB_DATA(8)) bus ();

    alu_ctrl #(
        .NB_DATA  (8),
        .NB_OP    (6),
        .ALU_LAT  (ALU_LAT),
        .ERR_CODE (ERR)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_q[$];
    int         n_xfer   = 0;
    int         n_ovr    = 0;
    int         n_en_op  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Returns {carry, zero, result}
    function automatic logic [9:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        logic [8:0] t;
        t = '0;
        case (op[7:2])
            6'b100000: t = {1'b0, a} + {1'b0, b};
            6'b100010: t = {1'b0, a} - {1'b0, b};
            6'b100100: t = {1'b0, a & b};
            6'b100101: t = {1'b0, a | b};
            6'b100111: t = {1'b0, ~(a | b)};
            6'b100110: t = {1'b0, a ^ b};
            6'b000010: t = {1'b0, a >> b};
            6'b000011: t = {1'b0, $unsigned($signed(a) >>> b)};
            default:   t = 9'h0A5;
        endcase
        return {t[8], (t[7:0] == 8'h00), t[7:0]};
    endfunction

    // ALU model: result only valid ALU_LAT cycles after the opcode strobe
    logic [7:0] m_a = '0, m_b = '0, m_op = '0;
    int         m_age = 0;
    logic [9:0] m_out;
    always @(posedge clk) begin
        if (bus.o_alu_en_a)  m_a <= bus.o_alu_data;
        if (bus.o_alu_en_b)  m_b <= bus.o_alu_data;
        if (bus.o_alu_en_op) begin
            m_op  <= bus.o_alu_data;
            m_age <= 1;
        end else if (m_age != 0 && m_age < 100) begin
            m_age <= m_age + 1;
        end
    end
    assign m_out            = alu_ref(m_a, m_b, m_op);
    assign bus.i_alu_result = (m_age >= ALU_LAT) ? m_out[7:0] : 8'hA5;
    assign bus.i_alu_carry  = (m_age >= ALU_LAT) ? m_out[9]   : 1'b1;
    assign bus.i_alu_zero   = (m_age >= ALU_LAT) ? m_out[8]   : 1'b1;

    // Output monitor: scoreboard pop, hold-under-stall, strobe exclusivity
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("en_onehot", ($countones({bus.o_alu_en_a, bus.o_alu_en_b, bus.o_alu_en_op}) > 1) ? 1 : 0, 0);
            if (bus.o_alu_en_op) n_en_op++;
            if (bus.o_overrun)   n_ovr++;
            if (prev_stall) begin
                check("tx_hold_valid", bus.o_tx_valid, 1);
                check("tx_hold_data", bus.o_tx_data, prev_data);
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) check("tx_unexpected", exp_q.size(), 1);
                else                   check("tx_data", bus.o_tx_data, exp_q.pop_front());
            end
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;
        end
    end

    task automatic push_exp(input logic [7:0] res, input logic [7:0] flg);
        exp_q.push_back(res);
`ifdef ALU_CTRL_FLAGS_EN
        exp_q.push_back(flg);
`else
        if (flg > 8'h03) $display("bad flag byte %0h", flg);
`endif
    endtask

    // kind: 0=A, 1=B, 2=valid opcode, 3=invalid opcode
    task automatic rx_byte_chk(input logic [7:0] b, input int kind);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
        @(negedge clk);
        check("en_a", bus.o_alu_en_a, (kind == 0) ? 1 : 0);
        check("en_b", bus.o_alu_en_b, (kind == 1) ? 1 : 0);
        check("en_op", bus.o_alu_en_op, (kind == 2) ? 1 : 0);
        if (kind < 3) begin
            check("alu_data", bus.o_alu_data, b);
        end else begin
            check("err_valid", bus.o_tx_valid, 1);
            check("err_data", bus.o_tx_data, ERR);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit valid);
        rx_byte_chk(a, 0);
        rx_byte_chk(b, 1);
        rx_byte_chk(op, valid ? 2 : 3);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.o_busy); i++) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
        check({tag, "_idle"}, bus.o_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         x0;
        int         o0;
        int         p0;
        logic [9:0] r;
        logic [7:0] ops[6];
        ops = '{8'h90, 8'h94, 8'h9C, 8'h98, 8'h08, 8'h0C};

        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", bus.o_tx_valid, 0);
        check("rst_tx_data", bus.o_tx_data, 0);
        check("rst_alu_data", bus.o_alu_data, 0);
        check("rst_en", {bus.o_alu_en_a, bus.o_alu_en_b, bus.o_alu_en_op}, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_overrun", bus.o_overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD with exact latency check: tx valid at opcode cycle + 4
        push_exp(8'h08, 8'h00);
        send_cmd(8'h05, 8'h03, 8'h80, 1'b1);
        @(negedge clk); check("lat_n2", bus.o_tx_valid, 0);
        @(negedge clk); check("lat_n3", bus.o_tx_valid, 0);
        @(negedge clk); check("lat_n4", bus.o_tx_valid, 1);
        check("lat_res", bus.o_tx_data, 8'h08);
        @(posedge clk); #1;
        drain("add_drain");

        push_exp(8'h02, 8'h00);
        send_cmd(8'h05, 8'h03, 8'h88, 1'b1);
        drain("sub_drain");

        // Invalid opcode: single ERR byte, no ALU strobe
        x0 = n_xfer; p0 = n_en_op;
        exp_q.push_back(ERR);
        send_cmd(8'h05, 8'h03, 8'h04, 1'b0);
        @(negedge clk); check("inv_single", bus.o_tx_valid, 0);
        drain("inv_drain");
        check("inv_xfers", n_xfer - x0, 1);
        check("inv_no_en_op", n_en_op - p0, 0);

        // Backpressure: hold for 5 cycles then accept
        bus.i_tx_ready = 1'b0;
        x0 = n_xfer;
        push_exp(8'h46, 8'h00);
        send_cmd(8'h12, 8'h34, 8'h80, 1'b1);
        for (int i = 0; i < 20 && !bus.o_tx_valid; i++) @(negedge clk);
        check("bp_valid", bus.o_tx_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_v", bus.o_tx_valid, 1);
            check("bp_hold_d", bus.o_tx_data, 8'h46);
        end
        @(posedge clk); #1;
        bus.i_tx_ready = 1'b1;
        drain("bp_drain");
        check("bp_xfers", n_xfer - x0, N_RSP);

        // Overrun: three bytes during EXEC/SEND_RES
        bus.i_tx_ready = 1'b0;
        o0 = n_ovr;
        push_exp(8'h1E, 8'h00);
        send_cmd(8'h0A, 8'h14, 8'h80, 1'b1);
        bus.i_rx_data  = 8'h77;
        bus.i_rx_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.i_tx_ready = 1'b1;
        drain("ovr_drain");
        check("ovr_count", n_ovr - o0, 3);
        check("ovr_alu_data", bus.o_alu_data, 8'h80);

        // Remaining operations
        foreach (ops[k]) begin
            r = alu_ref(8'hC6, 8'h03, ops[k]);
            push_exp(r[7:0], {6'b0, r[9], r[8]});
            send_cmd(8'hC6, 8'h03, ops[k], 1'b1);
            drain("op_drain");
        end

        // Reset after B accepted
        rx_byte_chk(8'h33, 0);
        rx_byte_chk(8'h44, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.o_busy, 0);
        check("mid_rst_alu_data", bus.o_alu_data, 0);
        check("mid_rst_tx", {bus.o_tx_valid, bus.o_tx_data}, 0);
        check("mid_rst_en", {bus.o_alu_en_a, bus.o_alu_en_b, bus.o_alu_en_op, bus.o_overrun}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); check("post_rst_busy", bus.o_busy, 0);
        @(posedge clk); #1;
        push_exp(8'h10, 8'h00);
        send_cmd(8'h40, 8'h02, 8'h0C, 1'b1);
        drain("post_rst_drain");

        // Carry and zero both set
        push_exp(8'h00, 8'h03);
        send_cmd(8'hFF, 8'h01, 8'h80, 1'b1);
        drain("flags_drain");

        check("en_op_total", n_en_op, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_ctrl.md
# alu_ctrl

Byte-stream sequencer that sits between a serial receiver/transmitter pair and the ALU. It collects operand A, operand B and opcode from received bytes and loads each into the ALU with one-cycle enable strobes. It waits out the ALU's registered latency, then returns the result, and optionally the flags, through a valid/ready transmit port. Opcode bytes that do not decode to a supported ALU operation are rejected without touching the ALU.

## Interface
- `NB_DATA`, 8, data/byte width
- `NB_OP`, 6, opcode field width (opcode = byte[NB_DATA-1 : NB_DATA-NB_OP])
- `ALU_LAT`, 2, cycles from `o_alu_en_op` until `i_alu_*` is valid (1..15)
- `ERR_CODE`, 8'hEE, byte transmitted for an invalid opcode
- `i_clk` in 1: single clock, rising edge
- `i_reset` in 1: asynchronous, active-high reset
- `i_rx_data` in NB_DATA: received byte
- `i_rx_valid` in 1: one-cycle strobe, byte present
- `o_alu_data` out NB_DATA: byte driven to the ALU data input
- `o_alu_en_a` / `o_alu_en_b` / `o_alu_en_op` out 1 each: one-cycle load strobes
- `i_alu_result` in NB_DATA: ALU result
- `i_alu_carry`, `i_alu_zero` in 1 each: ALU flags
- `o_tx_data` out NB_DATA: byte to transmit
- `o_tx_valid` out 1: transmit byte valid
- `i_tx_ready` in 1: transmitter accepts; transfer occurs when valid&&ready
- `o_busy` out 1: high in any state other than WAIT_A
- `o_overrun` out 1: one-cycle pulse, rx byte dropped

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, SEND_FLG (SEND_FLG only exists with the macro).
- WAIT_A/WAIT_B on `i_rx_valid`:
  - register the byte into `o_alu_data`;
  - pulse `o_alu_en_a`/`o_alu_en_b` the next cycle;
  - advance to the next state.
- WAIT_OP on `i_rx_valid`: decode byte[7:2] (NB_DATA=8).
  - Valid codes: 100000, 100010, 100100, 100101, 100111, 100110, 000010, 000011.
  - Valid: register byte, pulse `o_alu_en_op` next cycle, load latency counter with ALU_LAT, go to EXEC.
  - Invalid: no ALU strobe; load ERR_CODE into tx register; go to SEND_RES.
- EXEC: counter decrements each cycle; at zero, sample `i_alu_result` (and flags) into tx register; go to SEND_RES.
- SEND_RES: `o_tx_valid`=1 and `o_tx_data` held stable until a valid&&ready transfer. Then:
  - macro defined and opcode valid: go to SEND_FLG;
  - otherwise: go to WAIT_A.
- SEND_FLG: `o_tx_data`={NB_DATA-2 zeros, carry, zero}; on transfer go to WAIT_A.
- Exactly one `o_alu_en_*` may be high in any cycle.
- `i_rx_valid` in EXEC/SEND_RES/SEND_FLG: byte dropped, `o_overrun` pulses the next cycle, state unchanged.
- Reset values: all outputs 0, state WAIT_A, counter 0, tx/flag registers 0.
- Reset mid-operation: immediate return to WAIT_A; a partially collected command is discarded. The ALU is not cleared by this block.

## Timing
- rx byte at cycle N -> `o_alu_data` valid and matching `o_alu_en_*` high at cycle N+1 (registered). `o_alu_data` holds until the next accepted byte.
- Opcode at N -> `o_alu_en_op` at N+1 -> `i_alu_*` sampled at end of N+1+ALU_LAT -> `o_tx_valid` high from N+2+ALU_LAT.
- Invalid opcode at N -> `o_tx_valid` high at N+1.
- `i_tx_ready` high in the first SEND_RES cycle -> transfer that cycle; `o_tx_valid` drops next cycle, or, with the macro, is held for SEND_FLG.
- `o_tx_valid` is never deasserted without a transfer, except by reset.
- A new A byte is accepted in the cycle after the final transfer: minimum turnaround 1 cycle.

## Configuration
- `ALU_CTRL_FLAGS_EN` defined:
  - SEND_FLG exists;
  - each valid command returns 2 bytes (result, then flags).
- `ALU_CTRL_FLAGS_EN` undefined:
  - SEND_FLG and the flag registers are not built;
  - each command returns 1 byte;
  - `i_alu_carry`/`i_alu_zero` are unused.
- Invalid-opcode responses are always 1 byte (ERR_CODE) in both builds.

## Test plan
- A=0x05, B=0x03, op=0x80, ready tied high, bench ALU model with ALU_LAT=2:
  - en_a/en_b/en_op each seen once, in order, with `o_alu_data` 0x05/0x03/0x80;
  - tx 0x08 at opcode cycle+4.
- A=0x05, B=0x03, op=0x88 (SUB) -> tx 0x02.
- Op byte 0x04 -> no `o_alu_en_op`; tx 0xEE one cycle later; single byte in both builds.
- Backpressure: `i_tx_ready` low 5 cycles after result -> `o_tx_valid`=1 with data stable for 5 cycles; exactly one transfer.
- Send 3 extra rx bytes during EXEC/SEND_RES -> 3 `o_overrun` pulses, result unchanged; next command works normally.
- `i_reset` pulse after B accepted -> outputs 0, `o_busy`=0; full new command gives the correct result.
- With `ALU_CTRL_FLAGS_EN`, A=0xFF, B=0x01, op=0x80 -> tx result byte, then {6'b0, model carry, model zero}.
